// File: rtl/multi_channel_timer_component.sv
// Avalon-MM slave with NUM_CH down-counting timers (reload, one-shot/auto-reload, W1C pending, OR'd irq).
// Define TIMER_PRESCALER_EN to add the per-channel 8-bit PRESCALE field in CTRL[15:8].

package mct_pkg;
    typedef struct packed {
        logic        ld_count;
        logic        ld_ctrl;
        logic        clr_pend;
        logic        ld_reload;
        logic [31:0] wdata;
    } ch_wr_t;
endpackage

module mct_channel #(
    parameter int CNT_W = 27
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  mct_pkg::ch_wr_t      wr,
    output logic [3:0][31:0]     regs,
    output logic                 irq_req
);
    logic [CNT_W-1:0] count, reload;
    logic             enable, auto_reload, irq_en, pending;
    logic             tick, expire;
    logic [7:0]       prescale_rd;
    logic             unused_wdata;

    assign unused_wdata = ^wr.wdata;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] prescale, psc_cnt;

    assign tick        = enable && (psc_cnt == prescale);
    assign prescale_rd = prescale;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                   prescale <= '0;
        else if (wr.ld_ctrl)           prescale <= wr.wdata[15:8];
    end

    // Restart the divider on disable and on any CTRL/COUNT write so a fresh
    // programming sees a full PRESCALE+1 cycle period before its first tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                  psc_cnt <= '0;
        else if (!enable || wr.ld_ctrl || wr.ld_count) psc_cnt <= '0;
        else if (tick)                                psc_cnt <= '0;
        else                                          psc_cnt <= psc_cnt + 8'd1;
    end
`else
    assign tick        = enable;
    assign prescale_rd = 8'd0;
`endif

    assign expire  = tick && (count == '0);
    assign irq_req = pending & irq_en;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)               count <= '0;
        else if (wr.ld_count)      count <= wr.wdata[CNT_W-1:0];
        else if (tick) begin
            if (count != '0)       count <= count - CNT_W'(1);
            else if (auto_reload)  count <= reload;
        end
    end

    // A CTRL write beats the one-shot self-disable landing in the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            enable      <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
        end else if (wr.ld_ctrl) begin
            enable      <= wr.wdata[0];
            auto_reload <= wr.wdata[1];
            irq_en      <= wr.wdata[2];
        end else if (expire && !auto_reload) begin
            enable      <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)           pending <= 1'b0;
        else if (expire)       pending <= 1'b1;
        else if (wr.clr_pend)  pending <= 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)           reload <= '0;
        else if (wr.ld_reload) reload <= wr.wdata[CNT_W-1:0];
    end

    assign regs[0] = 32'(count);
    assign regs[1] = {16'd0, prescale_rd, 5'd0, irq_en, auto_reload, enable};
    assign regs[2] = {31'd0, pending};
    assign regs[3] = 32'(reload);
endmodule

module multi_channel_timer_component #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    logic [1:0]            ch_sel, reg_sel;
    logic                  wr_en, rd_en;
    logic [3:0][3:0][31:0] rd_words;
    logic [3:0]            irq_req;

    assign ch_sel  = address[3:2];
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read;

    // Unpopulated channel slots read as zero and swallow writes.
    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            mct_pkg::ch_wr_t req;
            assign req.ld_count  = wr_en && (ch_sel == 2'(c)) && (reg_sel == 2'd0);
            assign req.ld_ctrl   = wr_en && (ch_sel == 2'(c)) && (reg_sel == 2'd1);
            assign req.clr_pend  = wr_en && (ch_sel == 2'(c)) && (reg_sel == 2'd2) && writedata[0];
            assign req.ld_reload = wr_en && (ch_sel == 2'(c)) && (reg_sel == 2'd3);
            assign req.wdata     = writedata;

            mct_channel #(.CNT_W(CNT_W)) u_ch (
                .clock   (clock),
                .resetn  (resetn),
                .wr      (req),
                .regs    (rd_words[c]),
                .irq_req (irq_req[c])
            );
        end else begin : g_off
            assign rd_words[c] = '0;
            assign irq_req[c]  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)    readdata <= '0;
        else if (rd_en) readdata <= rd_words[ch_sel][reg_sel];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= |irq_req;
    end
endmodule

// File: tb/tb_multi_channel_timer_component.sv
// Directed bench for multi_channel_timer_component: 4-channel instance plus a NUM_CH=2 instance;
// read expectations go through a scoreboard queue and are popped when readdata lands.
module tb_multi_channel_timer_component;
    logic        clock, resetn;
    logic [3:0]  address;
    logic        chipselect, chipselect2, read, write;
    logic [31:0] writedata, readdata, readdata2;
    logic        irq, irq2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    multi_channel_timer_component #(.NUM_CH(4), .CNT_W(27)) dut (
        .clock(clock), .resetn(resetn), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    multi_channel_timer_component #(.NUM_CH(2), .CNT_W(27)) dut2 (
        .clock(clock), .resetn(resetn), .address(address), .chipselect(chipselect2),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata2), .irq(irq2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_irq(input string tag, input logic expv, input bit s2 = 1'b0);
        check(tag, {31'd0, s2 ? irq2 : irq}, {31'd0, expv});
    endtask

    // Bus ops start on a falling edge and return on the next one (one cycle each).
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input bit s2 = 1'b0);
        address = a; writedata = d; write = 1'b1;
        chipselect = !s2; chipselect2 = s2;
        @(negedge clock);
        write = 1'b0; chipselect = 1'b0; chipselect2 = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] expv, input string tag,
                          input bit s2 = 1'b0);
        logic [31:0] obs;
        address = a; read = 1'b1;
        chipselect = !s2; chipselect2 = s2;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clock);
        read = 1'b0; chipselect = 1'b0; chipselect2 = 1'b0;
        obs = s2 ? readdata2 : readdata;
        check(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; address = '0; chipselect = 1'b0; chipselect2 = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0;
        idle(3);
        check("rst_rdata", readdata, 32'd0);
        chk_irq("rst_irq", 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) bus_rd(4'(i), 32'd0, $sformatf("rst_rd_a%0d", i));
        chk_irq("rst_irq_after_reads", 1'b0);

        // ch0 auto-reload, period 6
        bus_wr(4'h3, 32'd5);
        bus_wr(4'h0, 32'd5);
        bus_wr(4'h1, 32'd7);
        idle(5);
        bus_rd(4'h2, 32'd0, "ch0_pend_before_6th_tick");
        chk_irq("ch0_irq_low", 1'b0);
        bus_rd(4'h2, 32'd1, "ch0_pend_at_6th_tick");
        chk_irq("ch0_irq_high", 1'b1);
        bus_rd(4'h0, 32'd4, "ch0_count_reloaded");
        bus_wr(4'h2, 32'd1);
        chk_irq("ch0_irq_still_high", 1'b1);
        bus_rd(4'h2, 32'd0, "ch0_pend_cleared");
        chk_irq("ch0_irq_cleared", 1'b0);
        bus_rd(4'h2, 32'd0, "ch0_pend_wait_a");
        bus_rd(4'h2, 32'd0, "ch0_pend_wait_b");
        bus_rd(4'h2, 32'd1, "ch0_second_expire");
        chk_irq("ch0_irq_second", 1'b1);
        bus_wr(4'h1, 32'd0);
        bus_wr(4'h2, 32'd1);
        idle(1);
        chk_irq("ch0_irq_off", 1'b0);

        // ch2 one-shot
        bus_wr(4'h8, 32'd3);
        bus_wr(4'h9, 32'd5);
        idle(3);
        bus_rd(4'hA, 32'd0, "ch2_pend_before_expire");
        bus_rd(4'hA, 32'd1, "ch2_pend_expire");
        bus_rd(4'h9, 32'd4, "ch2_ctrl_oneshot_off");
        bus_rd(4'h8, 32'd0, "ch2_count_stays_0");
        chk_irq("ch2_irq", 1'b1);
        bus_wr(4'hA, 32'd1);
        idle(1);
        chk_irq("ch2_irq_cleared", 1'b0);

        // ch1 reload 0, irq masked, clear collides with expire
        bus_wr(4'h7, 32'd0);
        bus_wr(4'h5, 32'd3);
        idle(2);
        bus_rd(4'h6, 32'd1, "ch1_pending");
        chk_irq("ch1_irq_masked", 1'b0);
        bus_wr(4'h6, 32'd1);
        bus_rd(4'h6, 32'd1, "ch1_set_beats_clear");
        chk_irq("ch1_irq_masked2", 1'b0);
        bus_wr(4'h5, 32'd0);
        bus_wr(4'h6, 32'd1);
        bus_rd(4'h6, 32'd0, "ch1_cleared_when_idle");

`ifdef TIMER_PRESCALER_EN
        bus_wr(4'hC, 32'd2);
        bus_wr(4'hD, 32'h0305);
        idle(11);
        bus_rd(4'hE, 32'd0, "ch3_psc_before_12");
        bus_rd(4'hE, 32'd1, "ch3_psc_expire_12");
        bus_rd(4'hD, 32'h0304, "ch3_psc_ctrl");
        bus_wr(4'hE, 32'd1);
`else
        bus_wr(4'hD, 32'hFF07);
        bus_rd(4'hD, 32'h7, "ch3_ctrl_hi_ignored");
        bus_wr(4'hD, 32'd0);
        bus_wr(4'hE, 32'd1);
`endif
        idle(1);
        chk_irq("ch3_irq_off", 1'b0);

        // NUM_CH=2 instance: out-of-range channel and running COUNT overwrite
        bus_wr(4'hC, 32'hFFFF_FFFF, 1'b1);
        bus_rd(4'hC, 32'd0, "d2_oor_count", 1'b1);
        bus_rd(4'hD, 32'd0, "d2_oor_ctrl", 1'b1);
        bus_rd(4'hF, 32'd0, "d2_oor_reload", 1'b1);
        bus_rd(4'h1, 32'd0, "d2_ch0_ctrl_untouched", 1'b1);
        bus_rd(4'h5, 32'd0, "d2_ch1_ctrl_untouched", 1'b1);
        chk_irq("d2_irq_low", 1'b0, 1'b1);
        bus_wr(4'h0, 32'd100, 1'b1);
        bus_wr(4'h1, 32'd1, 1'b1);
        idle(2);
        bus_wr(4'h0, 32'h7FF_FFFF, 1'b1);
        bus_rd(4'h0, 32'h7FF_FFFF, "d2_count_loaded", 1'b1);
        bus_rd(4'h0, 32'h7FF_FFFE, "d2_count_resumes", 1'b1);

        // async reset mid-count
        bus_wr(4'h3, 32'd9);
        bus_wr(4'h0, 32'd9);
        bus_wr(4'h1, 32'd7);
        idle(3);
        bus_rd(4'h3, 32'd9, "pre_rst_reload");
        #2 resetn = 1'b0;
        #1 check("mid_rst_rdata", readdata, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int r = 0; r < 4; r++) bus_rd(4'(r), 32'd0, $sformatf("post_rst_ch0_r%0d", r));
        bus_rd(4'h0, 32'd0, "post_rst_d2_count", 1'b1);
        chk_irq("post_rst_irq", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
